// File: rtl/cc_cfg_pkg.sv
// cc_cfg_pkg: register map, bit positions and shared enums for the CC config register bank
package cc_cfg_pkg;

    localparam logic [31:0] OFF_VERSION = 32'h000;
    localparam logic [31:0] OFF_CTRL    = 32'h004;
    localparam logic [31:0] OFF_STATUS  = 32'h008;
    localparam logic [31:0] OFF_CFG     = 32'h010;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STATUS_DONE = 0;
    localparam int STATUS_BUSY = 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    typedef enum logic [1:0] {DEC_RO, DEC_RW, DEC_W1C, DEC_ERR} dec_e;

endpackage

// File: rtl/cc_cfg_apb_fsm.sv
// cc_cfg_apb_fsm: APB handshake sequencing with programmable wait states
module cc_cfg_apb_fsm import cc_cfg_pkg::*; #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic psel,
    input  logic penable,
    output logic capture,
    output logic commit,
    output logic pready
);

    state_e     state;
    logic [3:0] cnt;

    // The setup phase is recognised while not in ACCESS; the snapshot and counter
    // load happen on the edge that ends it, so a zero-wait transfer takes two cycles.
    assign capture = state != ACCESS && psel && !penable;
    assign pready  = state == ACCESS && cnt == 4'd0;
    assign commit  = pready && psel && penable;

    // Advance through the access phase; a dropped psel abandons the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (capture) begin
            state <= ACCESS;
            cnt   <= 4'(WAIT_CYCLES);
        end else if (state == ACCESS && (!psel || pready)) begin
            state <= IDLE;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: rtl/cc_cfg_regbank.sv
// cc_cfg_regbank: APB version/control/status/config register bank for the CC datapath
module cc_cfg_regbank import cc_cfg_pkg::*; #(
    parameter int          ADDR_W      = 12,
    parameter int          NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] VERSION     = 32'h0001_2024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_W-1:0]       paddr_i,
    input  logic [31:0]             pwdata_i,
    input  logic [3:0]              pstrb_i,
    output logic                    pready_o,
    output logic [31:0]             prdata_o,
    output logic                    pslverr_o,
    output logic [32*NUM_REGS-1:0]  cfg_o,
    output logic                    start_o,
    input  logic                    done_i,
    input  logic                    busy_i,
    output logic                    irq_o
);

    logic                   capture, commit, wr, wr_ctrl, wr_w1c, wr_cfg, in_cfg;
    logic                   err_q, irq_en, done, start_q, irq_q;
    logic [31:0]            addr, rel, rd, prdata_q;
    logic [32*NUM_REGS-1:0] cfg_q;
    dec_e                   dec;

    cc_cfg_apb_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel_i),
        .penable (penable_i),
        .capture (capture),
        .commit  (commit),
        .pready  (pready_o)
    );

    // Address decode into access class and read-data selection.
    always_comb begin
        addr   = 32'(paddr_i);
        rel    = addr - OFF_CFG;
        in_cfg = addr >= OFF_CFG && rel[31:2] < 30'(NUM_REGS);
        dec    = addr[1:0] != 2'b00 ? DEC_ERR :
                 addr == OFF_VERSION ? (pwrite_i ? DEC_ERR : DEC_RO) :
                 addr == OFF_CTRL || in_cfg ? DEC_RW :
                 addr == OFF_STATUS ? DEC_W1C : DEC_ERR;
        rd     = addr == OFF_VERSION ? VERSION : 32'd0;
        if (addr == OFF_CTRL)
            rd[CTRL_IRQ_EN] = irq_en;
        if (addr == OFF_STATUS) begin
            rd[STATUS_DONE] = done;
            rd[STATUS_BUSY] = busy_i;
        end
        for (int k = 0; k < NUM_REGS; k++)
            if (in_cfg && rel[31:2] == 30'(k))
                rd = cfg_q[32*k +: 32];
    end

    // err_q belongs to the transfer in flight, so erroring writes never commit.
    assign wr      = commit && pwrite_i && !err_q;
    assign wr_ctrl = wr && dec == DEC_RW && addr == OFF_CTRL && pstrb_i[0];
    assign wr_cfg  = wr && dec == DEC_RW && in_cfg;
    assign wr_w1c  = wr && dec == DEC_W1C && pstrb_i[0];

    // Snapshot read data and error status at the end of the setup phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_q <= 32'd0;
            err_q    <= 1'b0;
        end else if (capture) begin
            prdata_q <= dec == DEC_ERR ? 32'd0 : rd;
            err_q    <= dec == DEC_ERR;
        end
    end

    // Register writes, start pulse, sticky DONE (set beats clear) and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                for (int b = 0; b < 4; b++)
                    if (wr_cfg && rel[31:2] == 30'(k) && pstrb_i[b])
                        cfg_q[32*k+8*b +: 8] <= pwdata_i[8*b +: 8];
            if (wr_ctrl)
                irq_en <= pwdata_i[CTRL_IRQ_EN];
            start_q <= wr_ctrl && pwdata_i[CTRL_START];
            done    <= done_i || (done && !(wr_w1c && pwdata_i[STATUS_DONE]));
            irq_q   <= done && irq_en;
        end
    end

    assign prdata_o  = prdata_q;
    assign pslverr_o = pready_o && err_q;
    assign cfg_o     = cfg_q;
    assign start_o   = start_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_cc_cfg_regbank.sv
// tb_cc_cfg_regbank: directed checks of the CC config register bank at 0 and 3 wait states
module tb_cc_cfg_regbank;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic         done = 1'b0, busy = 1'b0, done_at_commit = 1'b0;
    logic         pready0, pslverr0, start0, irq0, pready3, pslverr3, start3, irq3;
    logic [31:0]  prdata0, prdata3, rd;
    logic [255:0] cfg0, cfg3;
    logic         er;
    int           waits;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    cc_cfg_regbank #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready0),
        .prdata_o(prdata0), .pslverr_o(pslverr0), .cfg_o(cfg0), .start_o(start0),
        .done_i(done), .busy_i(busy), .irq_o(irq0)
    );

    cc_cfg_regbank #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready3),
        .prdata_o(prdata3), .pslverr_o(pslverr3), .cfg_o(cfg3), .start_o(start3),
        .done_i(done), .busy_i(busy), .irq_o(irq3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit w3, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat, output logic err, output int nw);
        @(negedge clk);
        psel0 = !w3; psel3 = w3; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        nw = 0;
        while (!(w3 ? pready3 : pready0) && nw < 20) begin
            @(negedge clk);
            nw++;
        end
        if (nw >= 20)
            check("pready_timeout", 64'(nw), 64'd0);
        rdat = w3 ? prdata3 : prdata0;
        err  = w3 ? pslverr3 : pslverr0;
        done = done_at_commit;
        @(negedge clk);
        done = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pready",  64'(pready0),  64'd0);
        check("rst_prdata",  64'(prdata0),  64'd0);
        check("rst_pslverr", 64'(pslverr0), 64'd0);
        check("rst_cfg",     64'(|cfg0),    64'd0);
        check("rst_start",   64'(start0),   64'd0);
        check("rst_irq",     64'(irq0),     64'd0);
        rst_n = 1'b1;

        xfer(0, 0, 12'h000, 32'd0, 4'h0, rd, er, waits);
        check("ver_data",  64'(rd),    64'h0001_2024);
        check("ver_err",   64'(er),    64'd0);
        check("ver_waits", 64'(waits), 64'd0);

        xfer(0, 1, 12'h018, 32'hDEAD_BEEF, 4'b0101, rd, er, waits);
        check("cfg2_wr_err", 64'(er),          64'd0);
        check("cfg2_out",    64'(cfg0[95:64]), 64'h00AD_00EF);
        xfer(0, 0, 12'h018, 32'd0, 4'h0, rd, er, waits);
        check("cfg2_rd",     64'(rd),          64'h00AD_00EF);

        xfer(0, 1, 12'h004, 32'h3, 4'hF, rd, er, waits);
        check("start_hi", 64'(start0), 64'd1);
        @(negedge clk);
        check("start_lo", 64'(start0), 64'd0);
        xfer(0, 0, 12'h004, 32'd0, 4'h0, rd, er, waits);
        check("ctrl_rd", 64'(rd), 64'h2);

        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        check("irq_lag", 64'(irq0), 64'd0);
        @(negedge clk);
        check("irq_set", 64'(irq0), 64'd1);

        busy = 1'b1;
        xfer(0, 0, 12'h008, 32'd0, 4'h0, rd, er, waits);
        busy = 1'b0;
        check("status_busy_done", 64'(rd), 64'h3);

        xfer(0, 1, 12'h008, 32'h1, 4'b1110, rd, er, waits);
        xfer(0, 0, 12'h008, 32'd0, 4'h0, rd, er, waits);
        check("w1c_no_strb", 64'(rd), 64'h1);

        xfer(0, 1, 12'h008, 32'h1, 4'b0001, rd, er, waits);
        @(negedge clk);
        check("irq_clr", 64'(irq0), 64'd0);
        xfer(0, 0, 12'h008, 32'd0, 4'h0, rd, er, waits);
        check("status_clr", 64'(rd), 64'h0);

        done_at_commit = 1'b1;
        xfer(0, 1, 12'h008, 32'h1, 4'b0001, rd, er, waits);
        done_at_commit = 1'b0;
        xfer(0, 0, 12'h008, 32'd0, 4'h0, rd, er, waits);
        check("set_beats_clr", 64'(rd), 64'h1);
        check("irq_after_set", 64'(irq0), 64'd1);

        xfer(0, 0, 12'h0FC, 32'd0, 4'h0, rd, er, waits);
        check("unmapped_err",  64'(er), 64'd1);
        check("unmapped_data", 64'(rd), 64'd0);
        xfer(0, 0, 12'h006, 32'd0, 4'h0, rd, er, waits);
        check("misalign_err",  64'(er), 64'd1);
        check("misalign_data", 64'(rd), 64'd0);
        xfer(0, 1, 12'h000, 32'hFFFF_FFFF, 4'hF, rd, er, waits);
        check("ver_wr_err",    64'(er), 64'd1);
        check("ver_wr_data",   64'(rd), 64'd0);
        xfer(0, 0, 12'h000, 32'd0, 4'h0, rd, er, waits);
        check("ver_kept",      64'(rd), 64'h0001_2024);
        check("ver_kept_err",  64'(er), 64'd0);
        xfer(0, 1, 12'h030, 32'h1234_5678, 4'hF, rd, er, waits);
        check("cfg_past_end_err", 64'(er), 64'd1);

        xfer(1, 1, 12'h010, 32'h1234_5678, 4'hF, rd, er, waits);
        check("w3_waits", 64'(waits),       64'd3);
        check("w3_err",   64'(er),          64'd0);
        check("w3_cfg0",  64'(cfg3[31:0]),  64'h1234_5678);

        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        check("abort_wait", 64'(pready3), 64'd0);
        @(negedge clk);
        psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_cfg0",   64'(cfg3[31:0]), 64'h1234_5678);
        check("abort_pready", 64'(pready3),    64'd0);
        xfer(1, 0, 12'h010, 32'd0, 4'h0, rd, er, waits);
        check("abort_rd",    64'(rd),    64'h1234_5678);
        check("abort_waits", 64'(waits), 64'd3);

        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_pready",  64'(pready3),  64'd0);
        check("arst_prdata",  64'(prdata3),  64'd0);
        check("arst_pslverr", 64'(pslverr3), 64'd0);
        check("arst_cfg3",    64'(|cfg3),    64'd0);
        check("arst_cfg0",    64'(|cfg0),    64'd0);
        check("arst_irq",     64'(irq0),     64'd0);
        check("arst_start",   64'(start3),   64'd0);
        psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 0, 12'h014, 32'd0, 4'h0, rd, er, waits);
        check("arst_no_write", 64'(rd), 64'd0);
        xfer(0, 0, 12'h004, 32'd0, 4'h0, rd, er, waits);
        check("arst_irq_en", 64'(rd), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_cfg_regbank.md
# cc_cfg_regbank

Parametrised APB configuration/status register bank for the CC subsystem, the next generation of the fixed version-only config slave. Provides a read-only version register, a control register with a self-clearing start pulse, a sticky W1C status/interrupt register, and NUM_REGS byte-writable configuration registers. Supports programmable APB wait states and error responses. Sits on the APB bus between the host bridge and the CC datapath.

## Interface
- ADDR_W, 12, APB address width; must cover 0x010 + 4*(NUM_REGS-1)
- NUM_REGS, 8, number of RW config registers (1..64)
- WAIT_CYCLES, 0, pready_o low cycles in each access phase (0..15)
- VERSION, 32'h0001_2024, value of the VERSION register
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  ADDR_W  APB byte address
- pwdata_i  in  32  APB write data
- pstrb_i  in  4  APB write byte strobes
- pready_o  out  1  APB ready
- prdata_o  out  32  APB read data
- pslverr_o  out  1  APB error
- cfg_o  out  32*NUM_REGS  config registers, reg k at bits [32k+31:32k]
- start_o  out  1  one-cycle start pulse
- done_i  in  1  datapath done pulse (sets DONE)
- busy_i  in  1  datapath busy level
- irq_o  out  1  registered interrupt

## Operation
- Register map: 0x000 VERSION RO; 0x004 CTRL (bit0 START write-1 pulse, reads 0; bit1 IRQ_EN RW); 0x008 STATUS (bit0 DONE sticky, W1C; bit1 BUSY RO = busy_i); 0x010+4k CFG[k] RW.
- Unused bits read 0, writes ignored.
- Error (pslverr_o=1 with pready_o): paddr_i[1:0]!=0, unmapped address, or write to VERSION. Erroring transfers change no state; prdata_o = 0.
- Writes honour pstrb_i per byte on CFG and CTRL. On STATUS, bit0 acts only when pstrb_i[0]=1.
- Write commits in the completing cycle (psel & penable & pready_o).
- START: write of 1 to CTRL bit0 makes start_o=1 the cycle after commit, for exactly 1 cycle.
- DONE: set by done_i. If done_i and a W1C of DONE occur in the same cycle, the set wins.
- irq_o is registered from DONE & IRQ_EN and updates one cycle after either changes.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> ACCESS unconditionally. Wait counter loads WAIT_CYCLES and read data is captured.
  - ACCESS: counter decrements each cycle while nonzero. pready_o = (ACCESS && cnt==0).
  - On completion -> SETUP if psel & !penable already present (back-to-back), else IDLE.
- Read data is a snapshot taken at the SETUP cycle and held in prdata_o until the next SETUP. STATUS reflects done_i/busy_i as of that snapshot.
- Aborted access: psel_i drops in ACCESS before completion -> IDLE, no write, no error.
- Async reset mid-transfer aborts it; no partial write occurs.

## Timing
- Reset values: pready_o 0, prdata_o 0, pslverr_o 0, cfg_o 0, start_o 0, irq_o 0, IRQ_EN 0, DONE 0, FSM IDLE.
- Transfer length is 2+WAIT_CYCLES cycles, from setup through completion.
- pslverr_o is valid only while pready_o=1 and is 0 otherwise.
- cfg_o updates the cycle after commit.
- No combinational path from APB inputs to any output. pready_o and pslverr_o derive from registered state only.

## Structure
- Package cc_cfg_pkg holds:
  - register offsets (VERSION, CTRL, STATUS, CFG base)
  - CTRL/STATUS bit positions
  - FSM state enum type
  - address-decode result enum (RO, RW, W1C, ERR)
- Sub-module cc_cfg_apb_fsm implements the APB handshake FSM and wait counter. Outputs are commit, capture, and pready. The top holds decode, registers, and the interrupt logic.

## Test plan
- Reset, then read 0x000 with WAIT_CYCLES=0 -> pready_o in the 2nd cycle, prdata_o=32'h0001_2024, pslverr_o=0.
- Write CFG[2]=0xDEAD_BEEF with pstrb=4'b0101, then read back -> 0x00AD_00EF. cfg_o reg 2 matches one cycle after commit.
- Write 0x3 to CTRL -> start_o high exactly 1 cycle; CTRL reads 0x2. Then pulse done_i -> irq_o=1 one cycle after DONE sets. Write 0x1 to STATUS -> DONE=0, irq_o drops.
- done_i asserted in the same cycle as the STATUS W1C commit -> DONE stays 1.
- Read 0x0FC, read 0x006, write 0x000 -> each returns pslverr_o=1, prdata_o=0; VERSION is unchanged.
- WAIT_CYCLES=3: write CFG[0] -> pready_o low for 3 access cycles. Repeat with psel_i dropped after 1 access cycle -> FSM returns to IDLE, CFG[0] unchanged. Assert rst_n low mid-access -> all outputs at reset values.
